// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in EXECUTE.
// One quotient bit per cycle; divide-by-zero and signed overflow finish in one cycle.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_en_e,
  input  logic [1:0]       div_ctrl_e,
  input  logic [WIDTH-1:0] dividend_e,
  input  logic [WIDTH-1:0] divisor_e,
  input  logic             hold,
  input  logic             kill,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             div_stall,
  output logic             busy,
  output logic [1:0]       o_dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvsr;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_sel_rem;
  logic [WIDTH-1:0]   r_result;

  logic               w_signed;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_div_zero;
  logic               w_ovf;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;

  assign w_signed   = ~div_ctrl_e[0];
  assign w_a_mag    = (w_signed && dividend_e[WIDTH-1]) ? -dividend_e : dividend_e;
  assign w_b_mag    = (w_signed && divisor_e[WIDTH-1])  ? -divisor_e  : divisor_e;
  assign w_div_zero = (divisor_e == '0);
  assign w_ovf      = w_signed && (dividend_e == {1'b1, {(WIDTH-1){1'b0}}}) &&
                      (divisor_e == '1);

  // Partial remainder stays below the divisor, so a non-negative trial fits in WIDTH bits.
  assign w_trial   = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvsr};
  assign w_rem_nxt = w_trial[WIDTH] ? {r_rem[WIDTH-2:0], r_quo[WIDTH-1]} : w_trial[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
  assign w_q_fix   = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_r_fix   = r_neg_r ? -w_rem_nxt : w_rem_nxt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (div_en_e) w_state_nxt = (w_div_zero || w_ovf) ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE: if (!hold) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (kill) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvsr    <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_sel_rem <= 1'b0;
      r_result  <= '0;
    end else if (!kill) begin
      case (r_state)
        S_IDLE: begin
          if (div_en_e) begin
            r_sel_rem <= div_ctrl_e[1];
            r_neg_q   <= w_signed && (dividend_e[WIDTH-1] ^ divisor_e[WIDTH-1]);
            r_neg_r   <= w_signed && dividend_e[WIDTH-1];
            r_quo     <= w_a_mag;
            r_dvsr    <= w_b_mag;
            r_rem     <= '0;
            r_cnt     <= CNT_W'(WIDTH - 1);
            // Special cases bypass the sign fix and land straight in DONE.
            if (w_div_zero)
              r_result <= div_ctrl_e[1] ? dividend_e : '1;
            else if (w_ovf)
              r_result <= div_ctrl_e[1] ? '0 : dividend_e;
          end
        end
        S_CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_result <= r_sel_rem ? w_r_fix : w_q_fix;
        end
        default: ;
      endcase
    end
  end

  assign result       = r_result;
  assign result_valid = (r_state == S_DONE);
  assign busy         = (r_state != S_IDLE);
  assign div_stall    = div_en_e && (r_state != S_DONE) && !kill;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed RV32M corner cases plus random operands, checked
// through an expected-result queue drained by an independent monitor.
module tb_div_unit;
  localparam int W = 32;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         div_en_e = 1'b0;
  logic [1:0]   div_ctrl_e = 2'b00;
  logic [W-1:0] dividend_e = '0;
  logic [W-1:0] divisor_e = '0;
  logic         hold = 1'b0;
  logic         kill = 1'b0;
  logic [W-1:0] result;
  logic         result_valid;
  logic         div_stall;
  logic         busy;
  logic [1:0]   o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .div_en_e(div_en_e), .div_ctrl_e(div_ctrl_e),
    .dividend_e(dividend_e), .divisor_e(divisor_e), .hold(hold), .kill(kill),
    .result(result), .result_valid(result_valid), .div_stall(div_stall),
    .busy(busy), .o_dbg_state(o_dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: RV32M semantics straight from the ISA rules.
  function automatic logic [W-1:0] ref_model(input logic [1:0] ctrl, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    int sa, sb;
    if (b == 0) return ctrl[1] ? a : 32'hFFFF_FFFF;
    if (ctrl[0]) return ctrl[1] ? (a % b) : (a / b);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return ctrl[1] ? 32'h0 : 32'h8000_0000;
    sa = a;
    sb = b;
    return ctrl[1] ? W'(sa % sb) : W'(sa / sb);
  endfunction

  function automatic int exp_stall(input logic [1:0] ctrl, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
    if (b == 0) return 1;
    if (!ctrl[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // monitor: pops on the first valid cycle, then demands a stable result
  logic         prev_valid = 1'b0;
  logic [W-1:0] held_result = '0;
  always @(negedge clk) begin
    if (result_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result_valid", {31'b0, result_valid}, '0);
      end else begin
        check("result", result, exp_q.pop_front());
      end
      held_result = result;
    end else if (result_valid && prev_valid) begin
      check("result_stable", result, held_result);
    end
    prev_valid = result_valid;
  end

  // drivers
  task automatic start_op(input logic [1:0] ctrl, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit push);
    @(posedge clk); #1;
    div_en_e   = 1'b1;
    div_ctrl_e = ctrl;
    dividend_e = a;
    divisor_e  = b;
    if (push) exp_q.push_back(ref_model(ctrl, a, b));
  endtask

  // Counts stall cycles from the current cycle (T0) and leaves us at the DONE negedge.
  task automatic wait_done(input int stall_req, input int hold_cycles);
    int n = 0;
    @(negedge clk);
    check("busy_at_t0", {31'b0, busy}, '0);
    while (div_stall && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("stall_cycles", W'(n), W'(stall_req));
    check("valid_at_done", {31'b0, result_valid}, 32'd1);
    check("busy_at_done", {31'b0, busy}, 32'd1);
    if (hold_cycles > 0) begin
      hold = 1'b1;
      for (int k = 0; k < hold_cycles; k++) begin
        @(negedge clk);
        check("hold_state", {30'b0, o_dbg_state}, {30'b0, ST_DONE});
        check("hold_stall", {31'b0, div_stall}, '0);
      end
      hold = 1'b0;
    end
  endtask

  task automatic end_op();
    @(posedge clk); #1;
    div_en_e = 1'b0;
    @(negedge clk);
    check("valid_cleared", {31'b0, result_valid}, '0);
    check("busy_cleared", {31'b0, busy}, '0);
  endtask

  task automatic run_op(input logic [1:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b);
    start_op(ctrl, a, b, 1'b1);
    wait_done(exp_stall(ctrl, a, b), 0);
    end_op();
  endtask

  initial begin
    logic [1:0]   c;
    logic [W-1:0] a, b;

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_result", result, '0);
    check("rst_valid", {31'b0, result_valid}, '0);
    check("rst_busy", {31'b0, busy}, '0);
    check("rst_stall", {31'b0, div_stall}, '0);
    @(posedge clk); #1;
    rst = 1'b1;

    // directed
    run_op(2'b00, 32'h14, 32'hFFFF_FFFD);
    run_op(2'b10, 32'h14, 32'hFFFF_FFFD);
    run_op(2'b01, 32'hFFFF_FFFF, 32'h2);
    run_op(2'b11, 32'hFFFF_FFFF, 32'h2);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h2);
    run_op(2'b00, 32'h5, 32'h0);
    run_op(2'b11, 32'h5, 32'h0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);

    // hold at DONE with the divide still asserted
    start_op(2'b01, 32'd1000, 32'd3, 1'b1);
    wait_done(33, 4);
    end_op();

    // back-to-back: second op enters the IDLE cycle right after DONE
    start_op(2'b01, 32'd100, 32'd7, 1'b1);
    wait_done(33, 0);
    start_op(2'b01, 32'd100, 32'd9, 1'b1);
    wait_done(33, 0);
    end_op();

    // kill at T10
    start_op(2'b00, 32'd12345, 32'd17, 1'b0);
    repeat (10) @(posedge clk);
    #1 kill = 1'b1;
    @(negedge clk);
    check("kill_stall", {31'b0, div_stall}, '0);
    @(posedge clk); #1;
    kill = 1'b0;
    div_en_e = 1'b0;
    @(negedge clk);
    check("kill_state", {30'b0, o_dbg_state}, {30'b0, ST_IDLE});
    check("kill_busy", {31'b0, busy}, '0);
    repeat (3) @(posedge clk);

    // reset at T20, op restarts with div_en_e still high
    start_op(2'b10, 32'hFFFF_FC00, 32'd7, 1'b1);
    repeat (20) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_state", {30'b0, o_dbg_state}, {30'b0, ST_IDLE});
    check("midrst_result", result, '0);
    check("midrst_busy", {31'b0, busy}, '0);
    rst = 1'b1;
    wait_done(33, 0);
    end_op();

    // random
    for (int i = 0; i < 24; i++) begin
      c = 2'($urandom_range(0, 3));
      a = $urandom();
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom() >> $urandom_range(0, 28);
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run_op(c, a, b);
    end

    repeat (4) @(posedge clk);
    check("queue_drained", W'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
